md5_guess_generator: RTL and testbench



---
 rtl/md5_guess_generator.sv | 164 ++++++++++++++++
 tb/tb_md5_guess_generator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/md5_guess_generator.sv
// Brute-force keyspace enumerator: emits one unpadded, MSB-first packed
// candidate per accepted cycle over [charmin, charmax], lengths start_len..max_len.
module md5_guess_generator #(
  parameter int unsigned COUNT_WIDTH   = 48,
  parameter int unsigned MAX_GUESS_LEN = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             start_len,
  input  logic [3:0]             max_len,
  input  logic [7:0]             charmin,
  input  logic [7:0]             charmax,
  input  logic                   advance,
  output logic [127:0]           guess,
  output logic [3:0]             guesslen,
  output logic                   guess_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int unsigned NPOS = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_d;
  logic [3:0]             max_len_q, max_len_d;
  logic [7:0]             cmin_q, cmin_d;
  logic [7:0]             cmax_q, cmax_d;
  logic [127:0]           guess_d;
  logic [3:0]             guesslen_d;
  logic                   guess_valid_d, busy_d, done_d, cfg_err_d;
  logic [COUNT_WIDTH-1:0] count_d;

  logic [127:0]           inc_guess;
  logic                   wrap;
  logic                   cfg_bad;

  // Fill the first len positions with ch, zero the rest.
  function automatic logic [127:0] fill(input logic [3:0] len, input logic [7:0] ch);
    logic [127:0] g;
    g = '0;
    for (int i = 0; i < 16; i++)
      if (4'(i) < len) g[8*(15-i) +: 8] = ch;
    return g;
  endfunction

  // Odometer step with position 0 as the least-significant digit.
  always_comb begin
    logic carry;
    inc_guess = guess;
    carry     = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (carry && (4'(i) < guesslen)) begin
        if (guess[8*(15-i) +: 8] == cmax_q) begin
          inc_guess[8*(15-i) +: 8] = cmin_q;
        end else begin
          inc_guess[8*(15-i) +: 8] = guess[8*(15-i) +: 8] + 8'd1;
          carry = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  assign cfg_bad = (start_len == 4'd0) || (start_len > max_len) ||
                   ({1'b0, max_len} > 5'(MAX_GUESS_LEN)) || (charmin > charmax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and next-output logic; start overrides everything.
  always_comb begin
    state_d       = state;
    max_len_d     = max_len_q;
    cmin_d        = cmin_q;
    cmax_d        = cmax_q;
    guess_d       = guess;
    guesslen_d    = guesslen;
    guess_valid_d = guess_valid;
    busy_d        = busy;
    done_d        = done;
    cfg_err_d     = cfg_err;
    count_d       = count;

    case (state)
      RUN: begin
        if (advance) begin
          count_d = (&count) ? count : count + COUNT_WIDTH'(1);
          if (wrap && (guesslen == max_len_q)) begin
            state_d       = DONE;
            guess_valid_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
          end else if (wrap) begin
            guesslen_d = guesslen + 4'd1;
            guess_d    = fill(guesslen + 4'd1, cmin_q);
          end else begin
            guess_d = inc_guess;
          end
        end
      end
      default: ;
    endcase

    if (start) begin
      max_len_d = max_len;
      cmin_d    = charmin;
      cmax_d    = charmax;
      count_d   = '0;
      if (cfg_bad) begin
        state_d       = DONE;
        guess_d       = '0;
        guesslen_d    = 4'd0;
        guess_valid_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b1;
        cfg_err_d     = 1'b1;
      end else begin
        state_d       = RUN;
        guess_d       = fill(start_len, charmin);
        guesslen_d    = start_len;
        guess_valid_d = 1'b1;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_len_q   <= 4'd0;
      cmin_q      <= 8'd0;
      cmax_q      <= 8'd0;
      guess       <= '0;
      guesslen    <= 4'd0;
      guess_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      count       <= '0;
    end else begin
      max_len_q   <= max_len_d;
      cmin_q      <= cmin_d;
      cmax_q      <= cmax_d;
      guess       <= guess_d;
      guesslen    <= guesslen_d;
      guess_valid <= guess_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      cfg_err     <= cfg_err_d;
      count       <= count_d;
    end
  end

  logic unused_npos;
  assign unused_npos = (NPOS == 16);

endmodule

// File: tb/tb_md5_guess_generator.sv
// Randomized bench for md5_guess_generator against an index-based keyspace model.
module tb_md5_guess_generator;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   start_len;
  logic [3:0]   max_len;
  logic [7:0]   charmin;
  logic [7:0]   charmax;
  logic         advance;
  logic [127:0] guess;
  logic [3:0]   guesslen;
  logic         guess_valid;
  logic         busy;
  logic         done;
  logic         cfg_err;
  logic [47:0]  count;

  int vectors = 0;
  int errors  = 0;

  md5_guess_generator #(.COUNT_WIDTH(48), .MAX_GUESS_LEN(15)) dut (
    .clk(clk), .rst(rst), .start(start), .start_len(start_len), .max_len(max_len),
    .charmin(charmin), .charmax(charmax), .advance(advance), .guess(guess),
    .guesslen(guesslen), .guess_valid(guess_valid), .busy(busy), .done(done),
    .cfg_err(cfg_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint ipow(input int k, input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * k;
    return r;
  endfunction

  // Guess number n of length len: base-k digits of n, least significant at position 0.
  function automatic logic [127:0] model_guess(input int len, input longint n, input int k,
                                               input logic [7:0] cmin);
    logic [127:0] g;
    longint r;
    g = '0;
    r = n;
    for (int i = 0; i < len; i++) begin
      g[127-8*i -: 8] = cmin + 8'(r % k);
      r = r / k;
    end
    return g;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_guess"}, guess, 128'(0));
    check({tag, "_len"},   128'(guesslen), 128'(0));
    check({tag, "_valid"}, 128'(guess_valid), 128'(0));
    check({tag, "_busy"},  128'(busy), 128'(0));
    check({tag, "_done"},  128'(done), 128'(0));
    check({tag, "_err"},   128'(cfg_err), 128'(0));
    check({tag, "_count"}, 128'(count), 128'(0));
  endtask

  // Entered and left at a negedge. abort_after>0 returns early (still in RUN).
  task automatic run_sweep(input int sl, input int ml, input int cmin, input int cmax,
                           input int stall_pct, input int abort_after);
    int     k, len, cycles, accepted;
    longint n, mcount;
    bit     finished, adv;
    k = cmax - cmin + 1;
    start = 1'b1;
    start_len = 4'(sl);
    max_len = 4'(ml);
    charmin = 8'(cmin);
    charmax = 8'(cmax);
    advance = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_len = 4'($urandom);
    max_len = 4'($urandom);
    charmin = 8'($urandom);
    charmax = 8'($urandom);
    len = sl; n = 0; mcount = 0; cycles = 0; accepted = 0; finished = 0;
    while (!finished) begin
      if (cycles > 5000) begin
        check("timeout", 128'(1), 128'(0));
        break;
      end
      check("valid", 128'(guess_valid), 128'(1));
      check("len",   128'(guesslen), 128'(len));
      check("guess", guess, model_guess(len, n, k, 8'(cmin)));
      check("count", 128'(count), 128'(mcount));
      check("busy",  128'(busy), 128'(1));
      check("done",  128'(done), 128'(0));
      check("err",   128'(cfg_err), 128'(0));
      if (abort_after != 0 && accepted == abort_after) begin
        advance = 1'b1;
        return;
      end
      adv = ($urandom_range(0, 99) >= stall_pct);
      advance = adv;
      if (adv) begin
        accepted++;
        mcount++;
        n++;
        if (n == ipow(k, len)) begin
          n = 0;
          len++;
          if (len > ml) finished = 1;
        end
      end
      @(negedge clk);
      cycles++;
    end
    for (int r = 0; r < 2; r++) begin
      check("fin_done",  128'(done), 128'(1));
      check("fin_valid", 128'(guess_valid), 128'(0));
      check("fin_busy",  128'(busy), 128'(0));
      check("fin_err",   128'(cfg_err), 128'(0));
      check("fin_count", 128'(count), 128'(mcount));
      check("fin_len",   128'(guesslen), 128'(ml));
      check("fin_guess", guess, model_guess(ml, ipow(k, ml) - 1, k, 8'(cmin)));
      advance = 1'b1;
      @(negedge clk);
    end
    advance = 1'b0;
  endtask

  task automatic run_bad(input int sl, input int ml, input int cmin, input int cmax);
    start = 1'b1;
    start_len = 4'(sl);
    max_len = 4'(ml);
    charmin = 8'(cmin);
    charmax = 8'(cmax);
    advance = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check("bad_done",  128'(done), 128'(1));
      check("bad_err",   128'(cfg_err), 128'(1));
      check("bad_busy",  128'(busy), 128'(0));
      check("bad_valid", 128'(guess_valid), 128'(0));
      check("bad_count", 128'(count), 128'(0));
      @(negedge clk);
    end
    advance = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_len = 4'd0;
    max_len = 4'd0;
    charmin = 8'd0;
    charmax = 8'd0;
    advance = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("rst");
    rst = 1'b0;
    advance = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle_zero("idle");
    end
    advance = 1'b0;

    run_sweep(1, 2, 8'h61, 8'h63, 0, 0);
    run_sweep(1, 2, 8'h61, 8'h63, 40, 0);
    run_bad(3, 2, 8'h61, 8'h63);
    run_bad(1, 2, 8'h7a, 8'h61);
    run_bad(0, 2, 8'h61, 8'h63);
    run_sweep(1, 2, 8'h61, 8'h63, 20, 5);
    run_sweep(4, 4, 8'h30, 8'h30, 0, 0);
    run_sweep(14, 15, 8'h78, 8'h78, 30, 0);

    // Asynchronous reset between edges during a sweep.
    start = 1'b1;
    start_len = 4'd1;
    max_len = 4'd3;
    charmin = 8'h61;
    charmax = 8'h63;
    @(negedge clk);
    start = 1'b0;
    advance = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle_zero("post_rst");
    end
    advance = 1'b0;

    for (int t = 0; t < 12; t++) begin
      int k, sl, ml, cmin, ab;
      k = $urandom_range(1, 4);
      sl = $urandom_range(1, 3);
      ml = $urandom_range(sl, 3);
      cmin = $urandom_range(0, 256 - k);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      run_sweep(sl, ml, cmin, cmin + k - 1, $urandom_range(0, 50), ab);
    end
    run_sweep(2, 2, 8'hfd, 8'hff, 10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
